// File: rtl/cnn_ctrl_pkg.sv
// Shared CNN control definitions: scheduler state encoding
// and the output-buffer address and lane widths.
package cnn_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int LANE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } sched_state_e;

endpackage

// File: rtl/conv_out_sched.sv
// Convolution output scheduler. It counts MAC steps per neuron,
// walks the pixels of each plane and then the output channels,
// and issues one output-buffer byte write per finished neuron.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : layer start pulse, honoured only in IDLE
//   mac_valid/mac_ready: one MAC accumulation step handshake
//   wr_valid/wr_ready  : finished-neuron write handshake
//   wr_addr, wr_lane   : output word address and byte lane
//   plane_done         : one-cycle pulse after a plane's last neuron
//   layer_done         : one-cycle pulse on return to IDLE
//   busy               : state is not IDLE
module conv_out_sched
    import cnn_ctrl_pkg::*;
#(
    parameter int TAPS       = 25,
    parameter int PLANE_SIZE = 784,
    parameter int OUT_CH     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mac_valid,
    output logic              mac_ready,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LANE_W-1:0] wr_lane,
    output logic              plane_done,
    output logic              layer_done,
    output logic              busy
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int OW = (OUT_CH > 4) ? $clog2(OUT_CH) : 2;

    localparam logic [TW-1:0]     TAP_LAST   = TW'(TAPS - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(PLANE_SIZE - 1);
    localparam logic [ADDR_W-1:0] PLANE_STEP = ADDR_W'(PLANE_SIZE);
    localparam logic [OW-1:0]     OCH_LAST   = OW'(OUT_CH - 1);

    if (TAPS < 1) begin : g_bad_taps
        $error("conv_out_sched: TAPS must be at least 1");
    end
    if ((OUT_CH / 4) * PLANE_SIZE > 65536) begin : g_bad_addr
        $error("conv_out_sched: layer does not fit a 16-bit address");
    end
    if ((OUT_CH < 4) || (OUT_CH % 4 != 0)) begin : g_bad_och
        $error("conv_out_sched: OUT_CH must be a multiple of 4");
    end

    sched_state_e      state_q, state_d;
    logic [TW-1:0]     tap_q, tap_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [OW-1:0]     och_q, och_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [LANE_W-1:0] wr_lane_q, wr_lane_d;
    logic              plane_done_q, plane_done_d;
    logic              layer_done_q, layer_done_d;

    logic mac_ready_c;
    logic step_acc;
    logic neuron_end;
    logic wr_hs;

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        pix_d        = pix_q;
        och_d        = och_q;
        base_d       = base_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_lane_d    = wr_lane_q;
        plane_done_d = 1'b0;
        layer_done_d = 1'b0;

        // A step is taken only if the write slot is free or draining
        // this cycle, so a stalled write can never be overwritten.
        mac_ready_c = (state_q == ST_RUN) && (!wr_valid_q || wr_ready);
        step_acc    = mac_valid && mac_ready_c;
        neuron_end  = step_acc && (tap_q == TAP_LAST);
        wr_hs       = wr_valid_q && wr_ready;

        if (wr_hs) begin
            wr_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    tap_d   = '0;
                    pix_d   = '0;
                    och_d   = '0;
                    base_d  = '0;
                end
            end
            ST_RUN: begin
                if (neuron_end) begin
                    tap_d      = '0;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = base_q + pix_q;
                    wr_lane_d  = och_q[1:0];
                    if (pix_q == PIX_LAST) begin
                        pix_d        = '0;
                        plane_done_d = 1'b1;
                        // Four channels share one word; move to the
                        // next group of planes after lane 3.
                        if (och_q[1:0] == 2'd3) begin
                            base_d = base_q + PLANE_STEP;
                        end
                        if (och_q == OCH_LAST) begin
                            och_d   = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            och_d = och_q + OW'(1);
                        end
                    end else begin
                        pix_d = pix_q + ADDR_W'(1);
                    end
                end else if (step_acc) begin
                    tap_d = tap_q + TW'(1);
                end
            end
            ST_FLUSH: begin
                if (wr_hs) begin
                    state_d      = ST_IDLE;
                    layer_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            pix_q        <= '0;
            och_q        <= '0;
            base_q       <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_lane_q    <= '0;
            plane_done_q <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            pix_q        <= pix_d;
            och_q        <= och_d;
            base_q       <= base_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_lane_q    <= wr_lane_d;
            plane_done_q <= plane_done_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign mac_ready  = mac_ready_c;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_lane    = wr_lane_q;
    assign plane_done = plane_done_q;
    assign layer_done = layer_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
